cpu_cycle_sequencer: RTL and testbench

//  Drives the CPU control-word decoder's inputs: the Gray-coded instruction cycle and the opcode fields.

---
 rtl/cpu_cycle_sequencer_pkg.sv | 85 ++++++++
 rtl/cpu_cycle_sequencer_gray.sv | 23 ++
 rtl/cpu_cycle_sequencer.sv | 74 +++++++
 tb/tb_cpu_cycle_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared cycle/opcode definitions for the instruction sequencer and the control-word decoder.
// One copy of the Gray cycle codes and the per-group last-cycle table serves both blocks.
package cpu_cycle_sequencer_pkg;

    localparam logic [3:0] CYCLE_0  = 4'b0000;
    localparam logic [3:0] CYCLE_1  = 4'b0001;
    localparam logic [3:0] CYCLE_2  = 4'b0011;
    localparam logic [3:0] CYCLE_3  = 4'b0010;
    localparam logic [3:0] CYCLE_4  = 4'b0110;
    localparam logic [3:0] CYCLE_5  = 4'b0111;
    localparam logic [3:0] CYCLE_6  = 4'b0101;
    localparam logic [3:0] CYCLE_7  = 4'b0100;
    localparam logic [3:0] CYCLE_8  = 4'b1100;
    localparam logic [3:0] CYCLE_9  = 4'b1101;
    localparam logic [3:0] CYCLE_10 = 4'b1111;
    localparam logic [3:0] CYCLE_11 = 4'b1110;
    localparam logic [3:0] CYCLE_12 = 4'b1010;
    localparam logic [3:0] CYCLE_13 = 4'b1011;
    localparam logic [3:0] CYCLE_14 = 4'b1001;
    localparam logic [3:0] CYCLE_15 = 4'b1000;

    localparam logic [3:0] GROUP_SINGLE_REG    = 4'h1;
    localparam logic [3:0] GROUP_MATH_CONSTANT = 4'h2;
    localparam logic [3:0] GROUP_MATH_REG      = 4'h3;
    localparam logic [3:0] GROUP_REG_MEMORY    = 4'h4;
    localparam logic [3:0] GROUP_STACK         = 4'h5;
    localparam logic [3:0] GROUP_BRANCH_JUMPS  = 4'h6;
    localparam logic [3:0] GROUP_EXTENDED      = 4'h7;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h0;
    localparam logic [3:0] OP_POP  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h0;

    localparam logic [3:0] LAST_BRANCH   = CYCLE_3;
    localparam logic [3:0] LAST_STANDARD = CYCLE_5;
    localparam logic [3:0] LAST_EXTENDED = CYCLE_8;

    typedef struct packed {
        logic [3:0] group;
        logic [3:0] op;
    } opcode_t;

    function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] bin_to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] last_cycle_for(input logic [3:0] group, input logic [3:0] last_default);
        logic [3:0] last;
        case (group)
            GROUP_BRANCH_JUMPS:  last = LAST_BRANCH;
            GROUP_SINGLE_REG,
            GROUP_MATH_CONSTANT,
            GROUP_MATH_REG,
            GROUP_REG_MEMORY,
            GROUP_STACK:         last = LAST_STANDARD;
            GROUP_EXTENDED:      last = LAST_EXTENDED;
            default:             last = last_default;
        endcase
        return last;
    endfunction

    function automatic logic op_is_illegal(input opcode_t opc);
        logic bad;
        case (opc.group)
            GROUP_SINGLE_REG,
            GROUP_MATH_CONSTANT,
            GROUP_MATH_REG,
            GROUP_REG_MEMORY,
            GROUP_BRANCH_JUMPS:  bad = 1'b0;
            GROUP_STACK:         bad = (opc.op != OP_PUSH) && (opc.op != OP_POP);
            GROUP_EXTENDED:      bad = (opc.op != OP_JMP);
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_gray.sv
// 4-bit Gray-coded cycle counter: clear wins over step, otherwise hold.
// Every 4-bit pattern is a legal Gray code, so the output can never leave the cycle set.
module cycle_gray_counter
    import cpu_cycle_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       clear,
    output logic [3:0] cycle
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= CYCLE_0;
        end else if (clear) begin
            cycle <= CYCLE_0;
        end else if (step) begin
            cycle <= bin_to_gray(gray_to_bin(cycle) + 4'd1);
        end
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Instruction cycle sequencer: Gray cycle count, opcode/operand fetch latches,
// group-dependent instruction length, halt at instruction boundaries and illegal-opcode flag.
module cpu_cycle_sequencer
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter logic [7:0] RESET_OPCODE = 8'h00,
    parameter logic [3:0] LAST_DEFAULT = 4'b0010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       mem_wait,
    input  logic       halt,
    output logic [3:0] cycle,
    output logic [3:0] operator_group,
    output logic [3:0] operator,
    output logic [3:0] rg1_sel,
    output logic [3:0] rg2_sel,
    output logic       instr_start,
    output logic       halted,
    output logic       illegal_op
);

    opcode_t    opcode;
    logic [7:0] operand;
    logic       at_cycle0;
    logic       halt_hold;
    logic       advance;
    logic       end_instr;
    logic       step;
    logic [3:0] cyc_idx;
    logic [3:0] last_idx;

    assign at_cycle0 = (cycle == CYCLE_0);
    assign halt_hold = at_cycle0 & halt;
    assign advance   = ~mem_wait & ~halt_hold;

    // Comparing ordinal positions (not codes) also sends any cycle past the group's end back to CYCLE_0.
    // In CYCLE_0..CYCLE_2 the stale opcode is harmless: every group's last cycle is CYCLE_3 or later.
    assign cyc_idx   = gray_to_bin(cycle);
    assign last_idx  = gray_to_bin(last_cycle_for(opcode.group, LAST_DEFAULT));
    assign end_instr = advance & (cyc_idx >= last_idx);
    assign step      = advance & ~end_instr;

    cycle_gray_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .clear (end_instr),
        .cycle (cycle)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode     <= RESET_OPCODE;
            operand    <= 8'h00;
            illegal_op <= 1'b0;
        end else if (mem_wait) begin
            illegal_op <= 1'b0;
        end else begin
            if (cycle == CYCLE_1) opcode  <= data_in;
            if (cycle == CYCLE_3) operand <= data_in;
            illegal_op <= end_instr & op_is_illegal(opcode);
        end
    end

    assign operator_group = opcode.group;
    assign operator       = opcode.op;
    assign rg1_sel        = operand[7:4];
    assign rg2_sel        = operand[3:0];
    assign instr_start    = at_cycle0 & advance;
    assign halted         = halt_hold;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Scoreboard bench for cpu_cycle_sequencer: directed instruction traces with hand-computed
// per-cycle expectations, checked by an independent monitor on the falling edge.
module tb_cpu_cycle_sequencer;
    import cpu_cycle_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       mem_wait = 1'b1;
    logic       halt = 1'b0;
    logic [3:0] cycle, operator_group, operator, rg1_sel, rg2_sel;
    logic       instr_start, halted, illegal_op;

    cpu_cycle_sequencer #(.RESET_OPCODE(8'h00), .LAST_DEFAULT(4'b0010)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .mem_wait       (mem_wait),
        .halt           (halt),
        .cycle          (cycle),
        .operator_group (operator_group),
        .operator       (operator),
        .rg1_sel        (rg1_sel),
        .rg2_sel        (rg2_sel),
        .instr_start    (instr_start),
        .halted         (halted),
        .illegal_op     (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cyc;
        logic [7:0] opc;
        logic [7:0] opr;
        logic       st;
        logic       ill;
        logic       hlt;
    } rec_t;

    rec_t exp_q[$];
    int   id_q[$];
    int   tests = 0;
    int   fails = 0;
    int   slot_id = 0;
    bit   done = 0;

    // Hand-listed Gray sequence CYCLE_0..CYCLE_15
    logic [3:0] gray_tab [0:15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                    4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                    4'b1010, 4'b1011, 4'b1001, 4'b1000};

    logic [7:0] prev_opc = 8'h00;
    logic [7:0] prev_opr = 8'h00;
    logic       prev_ill = 1'b0;

    task automatic slot(input logic [3:0] ecyc, input logic [7:0] d, input logic mw, input logic h,
                        input logic [7:0] eopc, input logic [7:0] eopr,
                        input logic est, input logic eill, input logic ehlt);
        rec_t r;
        @(posedge clk);
        #1;
        data_in  = d;
        mem_wait = mw;
        halt     = h;
        r.cyc = ecyc; r.opc = eopc; r.opr = eopr; r.st = est; r.ill = eill; r.hlt = ehlt;
        exp_q.push_back(r);
        id_q.push_back(slot_id);
        slot_id++;
    endtask

    // Runs run_n cycles of an n-cycle instruction; mem_wait for wait_n clocks in cycle wait_k; halt=1 from cycle halt_k.
    task automatic instr(input logic [7:0] opc, input logic [7:0] opr, input int n, input logic ill,
                         input int run_n, input int wait_k, input int wait_n, input int halt_k);
        for (int k = 0; k < run_n; k++) begin
            int reps;
            reps = (k == wait_k) ? wait_n + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                logic mw, h;
                logic [7:0] d;
                mw = (r < reps - 1);
                h  = (halt_k >= 0) && (k >= halt_k);
                d  = (k == 1) ? opc : (k == 3) ? opr : 8'hA5;
                slot(gray_tab[k], d, mw, h,
                     (k <= 1) ? prev_opc : opc,
                     (k <= 3) ? prev_opr : opr,
                     (k == 0) && !mw && !h,
                     (k == 0) && (r == 0) ? prev_ill : 1'b0,
                     1'b0);
            end
        end
        if (run_n == n) begin
            prev_opc = opc;
            prev_opr = opr;
            prev_ill = ill;
        end
    endtask

    // Scoreboard monitor plus running invariants
    logic [3:0] mon_prev_cyc = 4'b0000;
    logic [7:0] mon_prev_opc = 8'h00;
    logic       mon_prev_ok  = 1'b0;

    always @(negedge clk) begin
        rec_t act, e;
        int   id;
        act = '{cyc: cycle, opc: {operator_group, operator}, opr: {rg1_sel, rg2_sel},
                st: instr_start, ill: illegal_op, hlt: halted};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL slot%0d: got cyc=%b opc=%h opr=%h start=%b ill=%b halted=%b, expected cyc=%b opc=%h opr=%h start=%b ill=%b halted=%b",
                         id, act.cyc, act.opc, act.opr, act.st, act.ill, act.hlt,
                         e.cyc, e.opc, e.opr, e.st, e.ill, e.hlt);
            end
        end
        if (mon_prev_ok && reset) begin
            if (cycle != mon_prev_cyc && cycle != 4'b0000 && $countones(cycle ^ mon_prev_cyc) != 1) begin
                fails++;
                $display("FAIL gray_step: got %b after %b, required one-bit change or 0000", cycle, mon_prev_cyc);
            end
            if ({operator_group, operator} != mon_prev_opc && mon_prev_cyc != 4'b0001) begin
                fails++;
                $display("FAIL opcode_stable: got %h after %h while leaving cycle %b, required change only leaving 0001",
                         {operator_group, operator}, mon_prev_opc, mon_prev_cyc);
            end
        end
        mon_prev_cyc = cycle;
        mon_prev_opc = {operator_group, operator};
        mon_prev_ok  = reset;
    end

    initial begin
        // Reset state (mem_wait held so instr_start stays low while in reset)
        slot(4'b0000, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1 reset = 1'b1;

        instr(8'h30, 8'h12, 6, 1'b0, 6, -1, 0, -1);   // MATH_REG OP_ADD
        instr(8'h60, 8'h9C, 4, 1'b0, 4, -1, 0, -1);   // branch
        instr(8'h70, 8'h21, 9, 1'b0, 9, 5, 3, -1);    // EXTENDED OP_JMP, 3 wait clocks in CYCLE_5
        instr(8'h5F, 8'h33, 6, 1'b1, 6, -1, 0, -1);   // STACK, bad operator
        instr(8'hA3, 8'h44, 4, 1'b1, 4, -1, 0, -1);   // undefined group
        instr(8'h11, 8'h56, 6, 1'b0, 6, -1, 0, -1);   // SINGLE_REG
        instr(8'h31, 8'h45, 6, 1'b0, 6, -1, 0, 4);    // halt raised in CYCLE_4

        repeat (3) slot(4'b0000, 8'hA5, 1'b0, 1'b1, 8'h31, 8'h45, 1'b0, 1'b0, 1'b1);
        slot(4'b0000, 8'hA5, 1'b1, 1'b0, 8'h31, 8'h45, 1'b0, 1'b0, 1'b0);  // mem_wait beats halt release
        instr(8'h50, 8'h02, 6, 1'b0, 6, -1, 0, -1);   // STACK OP_PUSH, resumes from halt

        instr(8'h40, 8'h77, 6, 1'b0, 5, -1, 0, -1);   // abandoned in CYCLE_4 by reset
        @(negedge clk); #1 reset = 1'b0; mem_wait = 1'b1;
        slot(4'b0000, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1 reset = 1'b1;
        prev_opc = 8'h00; prev_opr = 8'h00; prev_ill = 1'b0;

        instr(8'h52, 8'h10, 6, 1'b1, 6, -1, 0, -1);   // STACK operator 2 is illegal
        instr(8'h71, 8'h0F, 9, 1'b1, 9, -1, 0, -1);   // EXTENDED non-JMP is illegal
        instr(8'h20, 8'hEE, 6, 1'b0, 6, -1, 0, -1);   // MATH_CONSTANT, shows the pulse from 71

        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            fails++;
            $display("FAIL watchdog: got no completion by 200000, required completion");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

endmodule
